// File: rtl/potential_decay_array.sv
// Potential decay array: holds neuron membrane potentials (IEEE-754 single)
// and, on each start pulse, sweeps every entry through a decay-rate divider,
// streams the decayed value out over a valid/ready port and writes it back.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   start             : one-cycle pulse, begins a sweep when idle
//   rate_global[3:0]  : decay code for all neurons, sampled on start
//   wr_en/addr/data   : potential write, accepted only when idle
//   out_valid/ready   : decayed-potential stream handshake
//   out_addr, out_data: neuron address and decayed potential
//   busy, done        : sweep in progress, one-cycle end-of-sweep pulse
//   wr_err            : one-cycle pulse for a dropped write
//
// Optional macro POTENTIAL_DECAY_PER_NEURON_RATE_EN adds rate_wr_en,
// rate_wr_addr, rate_wr_data and a per-neuron rate table that replaces
// rate_global.
//
// Rate codes: 0001 x, 0010 x/2, 0100 x/4, 1000 x/8, 0011 x/2 + x/4,
// anything else passes x through.

// Like-signed float adder for normal or zero operands. The decay path only
// ever adds x/2 and x/4 of the same value, so both inputs share a sign.
// Result is rounded to nearest, ties to even.
module fp_add_like_sign (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  logic        sign;
  logic [7:0]  ea;
  logic [7:0]  eb;
  logic [7:0]  big_e;
  logic [7:0]  d;
  logic [4:0]  sh;
  logic [26:0] big_m;
  logic [26:0] sml_m;
  logic [26:0] mask;
  logic        lost;
  logic [26:0] sml_al;
  logic [27:0] raw;
  logic [26:0] norm;
  logic [8:0]  e_n;
  logic        up;
  logic [24:0] rnd;
  logic [8:0]  e_r;
  logic [22:0] f_r;

  always_comb begin
    sign = a[31];
    ea   = a[30:23];
    eb   = b[30:23];
    if (ea >= eb) begin
      big_e = ea;
      d     = ea - eb;
      big_m = {1'b1, a[22:0], 3'b000};
      sml_m = {1'b1, b[22:0], 3'b000};
    end else begin
      big_e = eb;
      d     = eb - ea;
      big_m = {1'b1, b[22:0], 3'b000};
      sml_m = {1'b1, a[22:0], 3'b000};
    end
    // Bits shifted past the guard/round pair collapse into sticky.
    sh     = (d > 8'd26) ? 5'd27 : d[4:0];
    mask   = (27'd1 << sh) - 27'd1;
    lost   = |(sml_m & mask);
    sml_al = (sml_m >> sh) | {26'b0, lost};
    raw    = {1'b0, big_m} + {1'b0, sml_al};
    if (raw[27]) begin
      norm = {raw[27:2], raw[1] | raw[0]};
      e_n  = {1'b0, big_e} + 9'd1;
    end else begin
      norm = raw[26:0];
      e_n  = {1'b0, big_e};
    end
    up  = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd = {1'b0, norm[26:3]} + {24'b0, up};
    if (rnd[24]) begin
      e_r = e_n + 9'd1;
      f_r = rnd[23:1];
    end else begin
      e_r = e_n;
      f_r = rnd[22:0];
    end

    if (ea == 8'hFF) begin
      sum = a;
    end else if (eb == 8'hFF) begin
      sum = b;
    end else if (ea == 8'd0 && eb == 8'd0) begin
      sum = {sign, 31'b0};
    end else if (ea == 8'd0) begin
      sum = b;
    end else if (eb == 8'd0) begin
      sum = a;
    end else if (e_r >= 9'd255) begin
      sum = {sign, 8'hFF, 23'b0};
    end else begin
      sum = {sign, e_r[7:0], f_r};
    end
  end

endmodule

module potential_decay_array #(
  parameter int          NUM_NEURONS    = 32,
  parameter int          ADDR_W         = 5,
  parameter logic [31:0] INIT_POTENTIAL = 32'h41DED852
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        rate_global,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
`ifdef POTENTIAL_DECAY_PER_NEURON_RATE_EN
  input  logic              rate_wr_en,
  input  logic [ADDR_W-1:0] rate_wr_addr,
  input  logic [3:0]        rate_wr_data,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data,
  output logic              busy,
  output logic              done,
  output logic              wr_err
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EMIT,
    FIN
  } state_t;

  localparam logic [ADDR_W:0]   NUM_W = (ADDR_W+1)'(NUM_NEURONS);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_NEURONS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [31:0]       mem [NUM_NEURONS];
  logic [ADDR_W-1:0] addr;
  logic              last;
  logic              hs;
  logic              wr_ok;
  logic              wr_bad;
  logic [3:0]        rate_cur;
  logic [31:0]       src;
  logic [31:0]       half;
  logic [31:0]       quarter;
  logic [31:0]       eighth;
  logic [31:0]       three_q;
  logic [31:0]       decayed;

  // Divide by 2^k via the exponent field. Inf/NaN pass through; anything
  // that would reach exponent 0 or below (including zero and denormals)
  // becomes a zero carrying the original sign.
  function automatic logic [31:0] shr_exp(
    input logic [31:0] x,
    input logic [7:0]  k
  );
    if (x[30:23] == 8'hFF) begin
      return x;
    end else if (x[30:23] <= k) begin
      return {x[31], 31'b0};
    end else begin
      return {x[31], x[30:23] - k, x[22:0]};
    end
  endfunction

  assign last  = (addr == LAST);
  assign hs    = out_valid & out_ready;
  assign wr_ok = ({1'b0, wr_addr} < NUM_W);

`ifdef POTENTIAL_DECAY_PER_NEURON_RATE_EN
  logic [3:0] rates [NUM_NEURONS];
  logic       rate_ok;

  assign rate_ok  = ({1'b0, rate_wr_addr} < NUM_W);
  assign rate_cur = rates[addr];
  assign wr_bad   = (wr_en && (busy || !wr_ok)) ||
                    (rate_wr_en && (busy || !rate_ok));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        rates[i] <= 4'b0001;
      end
    end else if (state == IDLE && rate_wr_en && rate_ok) begin
      rates[rate_wr_addr] <= rate_wr_data;
    end
  end
`else
  logic [3:0] rate_q;

  assign rate_cur = rate_q;
  assign wr_bad   = wr_en && (busy || !wr_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      rate_q <= 4'b0001;
    end else if (state == IDLE && start) begin
      rate_q <= rate_global;
    end
  end
`endif

  assign src     = mem[addr];
  assign half    = shr_exp(src, 8'd1);
  assign quarter = shr_exp(src, 8'd2);
  assign eighth  = shr_exp(src, 8'd3);

  fp_add_like_sign u_add (
    .a   (half),
    .b   (quarter),
    .sum (three_q)
  );

  always_comb begin
    decayed = src;
    case (rate_cur)
      4'b0010: decayed = half;
      4'b0100: decayed = quarter;
      4'b1000: decayed = eighth;
      4'b0011: decayed = three_q;
      default: decayed = src;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = READ;
        end
      end
      READ: begin
        state_nxt = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = last ? FIN : READ;
        end
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  // Storage, sweep address and output registers. Idle writes and sweep
  // write-backs live in disjoint states, so they never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= '0;
      out_addr <= '0;
      out_data <= '0;
      wr_err   <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        mem[i] <= INIT_POTENTIAL;
      end
    end else begin
      wr_err <= wr_bad;
      if (state == IDLE) begin
        if (wr_en && wr_ok) begin
          mem[wr_addr] <= wr_data;
        end
        if (start) begin
          addr <= '0;
        end
      end
      if (state == READ) begin
        out_addr <= addr;
        out_data <= decayed;
      end
      if (hs) begin
        mem[out_addr] <= out_data;
        addr          <= addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_potential_decay_array.sv
// Scoreboard bench for potential_decay_array: random and directed sweeps
// checked against an arithmetic reference model of the decay rules.
`timescale 1ns/1ps
module tb_potential_decay_array;

  localparam int          N    = 32;
  localparam logic [31:0] INIT = 32'h41DED852;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  rate_global;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        busy;
  logic        done;
  logic        wr_err;
`ifdef POTENTIAL_DECAY_PER_NEURON_RATE_EN
  logic        rate_wr_en   = 1'b0;
  logic [4:0]  rate_wr_addr = '0;
  logic [3:0]  rate_wr_data = '0;
`endif

  always #5 clk = ~clk;

  potential_decay_array dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .rate_global  (rate_global),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
`ifdef POTENTIAL_DECAY_PER_NEURON_RATE_EN
    .rate_wr_en   (rate_wr_en),
    .rate_wr_addr (rate_wr_addr),
    .rate_wr_data (rate_wr_data),
`endif
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_addr     (out_addr),
    .out_data     (out_data),
    .busy         (busy),
    .done         (done),
    .wr_err       (wr_err)
  );

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model [N];
  logic [31:0] obs [N];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: divide by 2^k, flushing to signed zero below the normal range.
  function automatic logic [31:0] halve(input logic [31:0] x, input int k);
    int e;
    e = int'(x[30:23]);
    if (e == 255) return x;
    if (e <= k) return {x[31], 31'b0};
    return {x[31], 8'(e - k), x[22:0]};
  endfunction

  // Reference: x/2 + x/4 == 3*M scaled, rounded to nearest-even 24 bits.
  function automatic logic [31:0] three_quarters(input logic [31:0] x);
    int          e;
    int          s;
    int          ef;
    logic [31:0] h;
    logic [31:0] q;
    logic [63:0] p;
    logic [63:0] qv;
    logic [63:0] r;
    logic [63:0] hf;
    e = int'(x[30:23]);
    h = halve(x, 1);
    q = halve(x, 2);
    if (e == 255) return x;
    if (q[30:0] == 31'd0) return h;
    p = 64'({1'b1, x[22:0]}) * 64'd3;
    if (p >= 64'd33554432) begin
      s  = 2;
      ef = e;
    end else begin
      s  = 1;
      ef = e - 1;
    end
    qv = p >> s;
    r  = p - (qv << s);
    hf = 64'd1 << (s - 1);
    if (r > hf || (r == hf && qv[0])) qv = qv + 64'd1;
    if (qv == 64'd16777216) begin
      qv = qv >> 1;
      ef = ef + 1;
    end
    return {x[31], 8'(ef), qv[22:0]};
  endfunction

  function automatic logic [31:0] decay_ref(input logic [31:0] x,
                                            input logic [3:0] rate);
    case (rate)
      4'b0010: return halve(x, 1);
      4'b0100: return halve(x, 2);
      4'b1000: return halve(x, 3);
      4'b0011: return three_quarters(x);
      default: return x;
    endcase
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 5))
      0: v[30:23] = 8'($urandom_range(0, 4));
      1: v[30:23] = 8'hFF;
      2: v[30:23] = 8'($urandom_range(252, 254));
      3: v[22:0]  = '0;
      default: ;
    endcase
    return v;
  endfunction

  // Monitor: pops the scoreboard on every handshake and checks that a
  // stalled output holds still.
  initial begin : monitor
    logic        pv;
    logic        pr;
    logic [4:0]  pa;
    logic [31:0] pd;
    exp_t        e;
    pv = 1'b0;
    pr = 1'b0;
    pa = '0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr && out_valid) begin
          check("hold_addr", 32'(out_addr), 32'(pa));
          check("hold_data", out_data, pd);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out: addr %0d data %h, none queued",
                     out_addr, out_data);
          end else begin
            e = sb.pop_front();
            check("out_addr", 32'(out_addr), 32'(e.a));
            check("out_data", out_data, e.d);
            obs[out_addr] = out_data;
          end
        end
        pv = out_valid;
        pr = out_ready;
        pa = out_addr;
        pd = out_data;
      end
    end
  end

  task automatic write_word(input logic [4:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    model[a] = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    check("wr_err_idle", 32'(wr_err), 32'd0);
  endtask

  task automatic run_sweep(input logic [3:0] rate, input bit bp,
                           input int stall_at, input bit err_wr,
                           input bit with_wr, input logic [4:0] wa,
                           input logic [31:0] wd, input bit restart,
                           input int exp_cycles);
    int   n;
    int   stall_left;
    bit   got_done;
    bit   err_pending;
    exp_t e;
    if (with_wr) model[wa] = wd;
    for (int i = 0; i < N; i++) begin
      model[i] = decay_ref(model[i], rate);
      e.a = 5'(i);
      e.d = model[i];
      sb.push_back(e);
    end
    start       = 1'b1;
    rate_global = rate;
    wr_en       = with_wr;
    wr_addr     = wa;
    wr_data     = wd;
    @(posedge clk); #1;
    start       = 1'b0;
    wr_en       = 1'b0;
    rate_global = 4'($urandom);
    if (with_wr) check("wr_err_with_start", 32'(wr_err), 32'd0);
    n           = 0;
    stall_left  = 5;
    got_done    = 1'b0;
    err_pending = 1'b0;
    while (!got_done && n < 1000) begin
      n++;
      if (err_pending) begin
        check("wr_err_busy", 32'(wr_err), 32'd1);
        err_pending = 1'b0;
        wr_en       = 1'b0;
      end
      if (done) begin
        got_done = 1'b1;
      end else begin
        start = restart && (n == 20);
        if (stall_at >= 0 && out_valid && int'(out_addr) == stall_at &&
            stall_left > 0) begin
          out_ready = 1'b0;
          if (stall_left == 5 && err_wr) begin
            wr_en       = 1'b1;
            wr_addr     = 5'(stall_at);
            wr_data     = $urandom;
            err_pending = 1'b1;
          end
          stall_left--;
        end else begin
          out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        @(posedge clk); #1;
      end
    end
    start     = 1'b0;
    out_ready = 1'b1;
    if (!got_done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done, want done within 1000");
      sb.delete();
    end else begin
      if (exp_cycles > 0) check("done_latency", n, exp_cycles);
      @(posedge clk); #1;
      check("done_pulse_end", 32'(done), 32'd0);
      check("busy_after", 32'(busy), 32'd0);
      check("sb_drained", sb.size(), 32'd0);
    end
  endtask

  initial begin : stim
    int          n;
    logic [3:0]  rates [6];
    exp_t        e;
    rates[0] = 4'b0001;
    rates[1] = 4'b0010;
    rates[2] = 4'b0100;
    rates[3] = 4'b1000;
    rates[4] = 4'b0011;
    rates[5] = 4'b0000;
    rst         = 1'b1;
    start       = 1'b0;
    rate_global = 4'b0001;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    out_ready   = 1'b1;
    for (int i = 0; i < N; i++) begin
      model[i] = INIT;
      obs[i]   = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_out_data", out_data, 32'd0);

    run_sweep(4'b0001, 1'b0, -1, 1'b0, 1'b0, '0, '0, 1'b0, 65);

    write_word(5'd3, INIT);
    run_sweep(4'b0010, 1'b0, -1, 1'b0, 1'b0, '0, '0, 1'b0, 65);
    check("half_addr3", obs[3], 32'h415ED852);
    write_word(5'd3, INIT);
    run_sweep(4'b1000, 1'b0, -1, 1'b0, 1'b0, '0, '0, 1'b0, 65);
    check("eighth_addr3", obs[3], 32'h405ED852);

    write_word(5'd0, 32'h41000000);
    write_word(5'd1, 32'hC1000000);
    run_sweep(4'b0011, 1'b0, -1, 1'b0, 1'b0, '0, '0, 1'b0, 65);
    check("tq_pos", obs[0], 32'h40C00000);
    check("tq_neg", obs[1], 32'hC0C00000);

    write_word(5'd0, 32'h00800000);
    write_word(5'd1, 32'h80800000);
    write_word(5'd2, 32'h7F800000);
    run_sweep(4'b0100, 1'b0, -1, 1'b0, 1'b0, '0, '0, 1'b0, 65);
    check("q_underflow_pos", obs[0], 32'h00000000);
    check("q_underflow_neg", obs[1], 32'h80000000);
    check("q_inf", obs[2], 32'h7F800000);

    // Stall at address 7 with a dropped write, then confirm entry 7 holds
    // only the decayed value.
    run_sweep(4'b0010, 1'b0, 7, 1'b1, 1'b0, '0, '0, 1'b0, 70);
    run_sweep(4'b0001, 1'b0, -1, 1'b0, 1'b0, '0, '0, 1'b0, 65);

    // Write lands with start; a start pulse mid-sweep is ignored.
    run_sweep(4'b0011, 1'b0, -1, 1'b0, 1'b1, 5'd0, 32'h42280000, 1'b1, 65);

    // Reset in the middle of a sweep.
    for (int i = 0; i < N; i++) begin
      model[i] = decay_ref(model[i], 4'b0010);
      e.a = 5'(i);
      e.d = model[i];
      sb.push_back(e);
    end
    start       = 1'b1;
    rate_global = 4'b0010;
    @(posedge clk); #1;
    start = 1'b0;
    n     = 0;
    while (!(out_valid && out_addr == 5'd10) && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    check("abort_reached_addr10", 32'(out_addr), 32'd10);
    rst = 1'b1;
    check("abort_no_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_valid", 32'(out_valid), 32'd0);
    sb.delete();
    for (int i = 0; i < N; i++) model[i] = INIT;
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_idle_done", 32'(done), 32'd0);
    end
    run_sweep(4'b0001, 1'b0, -1, 1'b0, 1'b0, '0, '0, 1'b0, 65);

    for (int s = 0; s < 12; s++) begin
      repeat ($urandom_range(0, 6)) write_word(5'($urandom), rand_fp());
      run_sweep(rates[$urandom_range(0, 5)], 1'($urandom), -1, 1'b0,
                1'($urandom), 5'($urandom), rand_fp(), 1'b0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/potential_decay_array.md
POTENTIAL_DECAY_ARRAY -- requirements
Module: potential_decay_array

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 32: number of neuron potential entries held.
REQ-002 SHALL have parameter ADDR_W, default 5: neuron address width, with 2**ADDR_W >= NUM_NEURONS.
REQ-003 SHALL have parameter INIT_POTENTIAL, default 32'h41DED852: IEEE-754 single value loaded into every entry on reset.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1: one-cycle pulse that begins a decay sweep (timestep boundary).
REQ-007 SHALL have port rate_global, input, 4: decay-rate code used when per-neuron rates are compiled out.
REQ-008 SHALL have ports wr_en (input, 1), wr_addr (input, ADDR_W), wr_data (input, 32): potential write from the potential adder or initialisation.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_addr (output, ADDR_W), out_data (output, 32): decayed-potential stream.
REQ-010 SHALL have outputs busy (1), done (1, one-cycle pulse) and wr_err (1, one-cycle pulse).

Function
REQ-011 SHALL hold NUM_NEURONS 32-bit float potentials internally.
REQ-012 SHALL use FSM states IDLE, READ, EMIT, FIN; start in IDLE -> READ at address 0; READ -> EMIT; EMIT stays until out_valid && out_ready; then READ at next address, or FIN after address NUM_NEURONS-1; FIN -> IDLE.
REQ-013 SHALL assert busy in READ, EMIT and FIN; done SHALL pulse for the FIN cycle only.
REQ-014 SHALL present out_valid, out_addr and out_data in EMIT; out_addr/out_data SHALL remain stable while out_valid is high and out_ready is low.
REQ-015 SHALL write the decayed value back to the entry in the same cycle as the out handshake.
REQ-016 SHALL decode rate codes: 0001 = x, 0010 = x/2, 0100 = x/4, 1000 = x/8, 0011 = x/2 + x/4, computed by the team's Addition_Subtraction adder; any other code = x unchanged.
REQ-017 SHALL perform divide-by-2^k by exponent subtraction; if exponent <= k, result SHALL be signed zero (sign kept, exponent and mantissa 0), never wrapped.
REQ-018 SHALL pass exponent 0 (zero/denormal) as signed zero and exponent 255 (Inf/NaN) unchanged.
REQ-019 SHALL ignore start while busy.
REQ-020 SHALL accept wr_en only in IDLE (write visible next cycle); wr_en while busy SHALL be dropped and pulse wr_err; wr_addr >= NUM_NEURONS SHALL be dropped and pulse wr_err.
REQ-021 SHALL give wr_en priority over start in the same IDLE cycle: the write lands, then the sweep begins next cycle.
REQ-022 SHALL take minimum 2*NUM_NEURONS+1 cycles from start to done with out_ready held high.

Reset
REQ-023 SHALL, on rst, force IDLE, load INIT_POTENTIAL into all entries, set all per-neuron rates to 0001, and drive busy, done, wr_err, out_valid low and out_addr, out_data to 0.
REQ-024 SHALL abort an in-progress sweep on rst with no done pulse; partially written-back entries are overwritten by INIT_POTENTIAL.

Configuration
REQ-025 SHALL, with macro POTENTIAL_DECAY_PER_NEURON_RATE_EN defined, add ports rate_wr_en (1), rate_wr_addr (ADDR_W), rate_wr_data (4) and a per-neuron rate table written only in IDLE (else dropped, wr_err pulsed); each neuron decays by its own code.
REQ-026 SHALL, without POTENTIAL_DECAY_PER_NEURON_RATE_EN, omit those ports and the table and apply rate_global, sampled on the start cycle, to all neurons for that sweep.

Verification
REQ-027 SHALL verify reset then start, rate 0001, out_ready high: 32 outputs, addr 0..31, each 0x41DED852; done exactly 65 cycles after start.
REQ-028 SHALL verify wr_addr 3 = 0x41DED852, rate 0010 -> out_data at addr 3 = 0x415ED852; rate 1000 on the next sweep -> 0x405ED852.
REQ-029 SHALL verify 0x41000000 (8.0), rate 0011 -> 0x40C00000 (6.0); 0xC1000000 -> 0xC0C00000.
REQ-030 SHALL verify 0x00800000, rate 0100 -> 0x00000000; 0x80800000 -> 0x80000000; 0x7F800000 -> 0x7F800000.
REQ-031 SHALL verify out_ready low 5 cycles at addr 7: out_addr/out_data stable, no write-back until handshake; wr_en during sweep -> wr_err pulse, entry unchanged.
REQ-032 SHALL verify rst asserted at addr 10 mid-sweep: no done, busy low next cycle, next sweep outputs INIT_POTENTIAL for all addresses.
